// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: PC register loop, instruction-memory handshake and IF/ID slot.
interface fetch_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] pc_cur;
   logic [XLEN-1:0] pc_next;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_instr;

   modport master (
      input  pc_cur, redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
      output pc_next, imem_req, imem_addr, id_valid, id_pc, id_instr
   );

   modport slave (
      output pc_cur, redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
      input  pc_next, imem_req, imem_addr, id_valid, id_pc, id_instr
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives next-PC, issues imem requests, fills the IF/ID slot
// through a one-entry skid buffer and discards responses orphaned by redirects.
module fetch_sequencer #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     PC_STEP   = 4,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
   input logic                clk,
   input logic                rst,
   fetch_sequencer_if.master  bus
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_OUT, DROP} state_t;

   state_t          state;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] skid_pc;
   logic [XLEN-1:0] skid_instr;
   logic [XLEN-1:0] drop_addr;

   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] pc_seq;
   logic            xfer;
   logic            slot_free;

   assign redirect_target = bus.redirect_pc & ~XLEN'(3);
   assign pc_seq          = bus.pc_cur + XLEN'(PC_STEP);
   assign xfer            = id_valid && bus.id_ready;
   assign slot_free       = !id_valid || bus.id_ready;

   assign bus.id_valid = id_valid;
   assign bus.id_pc    = id_pc;
   assign bus.id_instr = id_instr;

   always_comb begin
      bus.imem_req  = 1'b0;
      bus.imem_addr = bus.pc_cur;
      bus.pc_next   = bus.pc_cur;
      if (!rst) begin
         bus.pc_next = '0;
      end else begin
         case (state)
            FETCH: begin
               bus.imem_req = 1'b1;
               if (bus.imem_ack) bus.pc_next = pc_seq;
            end
            DROP: begin
               bus.imem_req  = 1'b1;
               bus.imem_addr = drop_addr;
            end
            default: ;
         endcase
         if (bus.redirect_valid) bus.pc_next = redirect_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         id_valid  <= 1'b0;
         id_pc     <= '0;
         id_instr  <= NOP_INSTR;
         drop_addr <= '0;
      end else if (bus.redirect_valid) begin
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
         case (state)
            FETCH: begin
               if (!bus.imem_ack) begin
                  drop_addr <= bus.pc_cur;
                  state     <= DROP;
               end else begin
                  state <= FETCH;
               end
            end
            DROP:    if (bus.imem_ack) state <= FETCH;
            default: state <= FETCH;
         endcase
      end else begin
         if (xfer) id_valid <= 1'b0;
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (bus.imem_ack) begin
                  if (slot_free) begin
                     id_valid <= 1'b1;
                     id_pc    <= bus.pc_cur;
                     id_instr <= bus.imem_rdata;
                  end else begin
                     state <= WAIT_OUT;
                  end
               end
            end
            // Skid occupancy is exactly state==WAIT_OUT, so no separate flag.
            WAIT_OUT: begin
               if (xfer) begin
                  id_valid <= 1'b1;
                  id_pc    <= skid_pc;
                  id_instr <= skid_instr;
                  state    <= FETCH;
               end
            end
            DROP: if (bus.imem_ack) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == FETCH && bus.imem_ack && !slot_free) begin
         skid_pc    <= bus.pc_cur;
         skid_instr <= bus.imem_rdata;
      end
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch-stage sequencer sitting on both sides of the program counter register.
- Consumes the current PC and drives its next-PC input. The PC register loads pc_next unconditionally every cycle, so holding means pc_next = pc_cur.
- Issues instruction-memory requests over a req/ack handshake and buffers returned instructions into a valid/ready IF/ID output slot with a one-entry skid buffer.
- Handles branch/jump redirects, including discarding an in-flight memory response.

Parameters:
- XLEN, 32, address/data width.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_INSTR, 32'h00000013, value of id_instr at reset and on flush (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-low reset.
- pc_cur  input  XLEN  current PC from the PC register output.
- pc_next  output  XLEN  next PC, drives the PC register input (combinational).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  XLEN  redirect target.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  XLEN  request address.
- imem_ack  input  1  response valid this cycle, with imem_rdata.
- imem_rdata  input  XLEN  fetched instruction.
- id_valid  output  1  IF/ID slot holds an instruction.
- id_ready  input  1  decode accepts the slot this cycle.
- id_pc  output  XLEN  PC of the slot instruction.
- id_instr  output  XLEN  slot instruction.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE, id_valid=0, id_pc=0, id_instr=NOP_INSTR, skid empty, drop_addr=0.
  - While rst==0, pc_next=0 and imem_req=0.
- Slot transfer occurs on a cycle with id_valid && id_ready. "Slot free" = !id_valid || id_ready.
- Memory protocol:
  - Once imem_req rises, imem_req and imem_addr stay stable until imem_ack.
  - imem_ack may arrive in the same cycle as the first req cycle (zero wait) or any later cycle.
  - imem_ack with imem_req low is ignored.
- Redirect target: redirect_pc[1:0] forced to 2'b00. pc_cur+PC_STEP wraps modulo 2^XLEN.
- IDLE:
  - imem_req=0, pc_next=pc_cur; next state FETCH.
  - On redirect: pc_next=redirect target.
- FETCH:
  - imem_req=1, imem_addr=pc_cur.
  - On ack with slot free: slot<=(pc_cur, rdata), id_valid<=1, pc_next=pc_cur+PC_STEP; stay FETCH.
  - On ack with slot not free: skid<=(pc_cur, rdata), pc_next=pc_cur+PC_STEP; go WAIT_OUT.
  - No ack: pc_next=pc_cur.
- WAIT_OUT:
  - imem_req=0, pc_next=pc_cur.
  - On slot transfer: slot<=skid, skid empty; go FETCH.
- DROP:
  - imem_req=1, imem_addr=drop_addr (the address of the abandoned request), pc_next=pc_cur.
  - On ack: response discarded; go FETCH.
- Redirect (any state except reset), highest priority:
  - pc_next=redirect target. id_valid<=0, id_instr<=NOP_INSTR, skid emptied.
  - A simultaneous slot transfer still counts for decode.
  - FETCH without ack: drop_addr<=pc_cur; go DROP.
  - FETCH with ack, or WAIT_OUT: response discarded; go FETCH.
  - DROP without ack: stay DROP, drop_addr unchanged.
  - DROP with ack: go FETCH.
  - IDLE: go FETCH.
- Throughput: one instruction per cycle with zero-wait memory and id_ready held high.
- Latency: one cycle from ack to id_valid.
- Reset mid-request: the request is abandoned. Memory reset is the system's responsibility.

Test Plan:
- Zero-wait sequential: reset then release with pc_cur following pc_next, ack tied high, id_ready=1 -> id_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, id_instr matches memory model.
- Wait states: ack 3 cycles after req at addr 0x10 -> imem_req high with imem_addr=0x10 stable all 4 cycles, pc_next=0x10 until ack, then 0x14.
- Backpressure: id_ready=0 with slot full and ack at 0x8 -> WAIT_OUT, imem_req=0, pc_next held at 0xC; raise id_ready -> id_pc=0x8 next cycle, fetch resumes at 0xC.
- Redirect while outstanding: req at 0x20 pending, redirect_valid to 0x103 -> pc_next=0x100, id_valid=0, imem_addr stays 0x20 until ack; the 0x20 data never appears; the next id_pc is 0x100.
- Redirect same cycle as ack: ack at 0x40 with redirect to 0x200 -> 0x40 discarded, next fetch at 0x200.
- Reset mid-stream: rst=0 during WAIT_OUT -> id_valid=0, id_instr=0x00000013, imem_req=0, pc_next=0; after release fetch restarts at 0x0.
